// File: rtl/caxi4dma_pkg.sv
// Shared definitions for the AXI4 DMA channel: FSM state encoding,
// destination-operation and AXI burst-type codes, and the bytes-per-beat helper.
package caxi4dma_pkg;

    // One-hot transaction-controller states.
    typedef enum logic [6:0] {
        ST_IDLE      = 7'b000_0001,
        ST_CALC      = 7'b000_0010,
        ST_WAIT_DATA = 7'b000_0100,
        ST_REQ       = 7'b000_1000,
        ST_RESP      = 7'b001_0000,
        ST_DONE      = 7'b010_0000,
        ST_ERROR     = 7'b100_0000
    } state_e;

    // Destination operation codes carried by the start command.
    localparam logic [1:0] DSTOP_NOP     = 2'b00;
    localparam logic [1:0] DSTOP_INCR    = 2'b01;
    localparam logic [1:0] DSTOP_FIXED   = 2'b10;
    localparam logic [1:0] DSTOP_ILLEGAL = 2'b11;

    // AXI4 AWBURST encodings.
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // log2 of the bytes per beat for a given data width in bits.
    function automatic int bpb_log2(input int dwidth);
        return $clog2(dwidth / 8);
    endfunction

endpackage

// File: rtl/caxi4dma_burst_sizer.sv
// Combinational burst sizer: the burst length in beats is the smallest of the
// remaining beats, the priority limit and (when SPLIT_4K is set, INCR only)
// the beats left before the next 4 KB boundary.
module caxi4dma_burst_sizer #(
    parameter int REM_WIDTH = 23,
    parameter int BPB_LOG2  = 3,
    parameter bit SPLIT_4K  = 1'b0
) (
    input  logic [REM_WIDTH-1:0] rem_beats_i,
    input  logic [8:0]           pri_beats_i,
    input  logic [11:0]          addr_lo_i,
    input  logic                 incr_i,
    output logic [8:0]           burst_beats_o
);

    logic [12:0] k4_bytes;
    logic [12:0] k4_beats;

    // Take the minimum of the three limits.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        burst_beats_o = pri_beats_i;
        k4_bytes      = 13'd4096 - {1'b0, addr_lo_i};
        k4_beats      = k4_bytes >> BPB_LOG2;
        if (rem_beats_i < REM_WIDTH'(pri_beats_i)) begin
            burst_beats_o = rem_beats_i[8:0];
        end
        if (SPLIT_4K && incr_i && (k4_beats < {4'b0000, burst_beats_o})) begin
            burst_beats_o = k4_beats[8:0];
        end
    end

endmodule

// File: rtl/caxi4dma_wr_tran_ctrl.sv
// Write-side transaction controller of the AXI4 DMA channel. Splits a start
// command into AXI4 write bursts, hands each one to the write master with a
// req/ack handshake, waits for its B response and reports done/error.
// Optional feature: define CAXI4DMA_WR_4K_SPLIT_EN to stop INCR bursts from
// crossing a 4 KB boundary; left undefined, software keeps transfers inside 4 KB.
module caxi4dma_wr_tran_ctrl
    import caxi4dma_pkg::*;
#(
    parameter int LEN_WIDTH          = 23,
    parameter int DWIDTH             = 64,
    parameter int NUM_PRI_LVLS       = 1,
    parameter int PRI_0_NUM_OF_BEATS = 255,
    parameter int PRI_1_NUM_OF_BEATS = 127,
    parameter int PRI_2_NUM_OF_BEATS = 63,
    parameter int PRI_3_NUM_OF_BEATS = 31
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    strTran,
    input  logic [31:0]             strDstAddr,
    input  logic [LEN_WIDTH-1:0]    strBytes,
    input  logic [1:0]              strDstOp,
    input  logic [NUM_PRI_LVLS-1:0] strPri,
    input  logic [8:0]              bufBeats,
    input  logic                    wrReqAck,
    input  logic                    wrDone,
    input  logic                    wrErr,
    output logic                    wrReq,
    output logic [31:0]             wrAddr,
    output logic [7:0]              wrLen,
    output logic [1:0]              wrBurst,
    output logic                    busy,
    output logic                    tranDone,
    output logic                    tranErr,
    output logic [31:0]             errAddr
);

    localparam int BPB_LOG2 = bpb_log2(DWIDTH);
    localparam logic [31:0] ADDR_MASK = 32'((1 << BPB_LOG2) - 1);
    localparam logic [LEN_WIDTH:0] BPB_M1 = (LEN_WIDTH + 1)'((1 << BPB_LOG2) - 1);
`ifdef CAXI4DMA_WR_4K_SPLIT_EN
    localparam bit SPLIT_4K = 1'b1;
`else
    localparam bit SPLIT_4K = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    rem_q, rem_d;
    logic [8:0]              beats_q, beats_d;
    logic [NUM_PRI_LVLS-1:0] pri_q, pri_d;
    logic                    wrReq_q, wrReq_d;
    logic [31:0]             wrAddr_q, wrAddr_d;
    logic [7:0]              wrLen_q, wrLen_d;
    logic [1:0]              wrBurst_q, wrBurst_d;
    logic                    busy_q, busy_d;
    logic                    tranDone_q, tranDone_d;
    logic                    tranErr_q, tranErr_d;
    logic [31:0]             errAddr_q, errAddr_d;

    logic [LEN_WIDTH:0]      bytes_rnd;
    logic [LEN_WIDTH-1:0]    start_beats;
    logic [31:0]             start_addr;
    logic [3:0]              pri_w;
    logic [8:0]              pri_beats;
    logic [8:0]              sized_beats;

    assign bytes_rnd   = {1'b0, strBytes} + BPB_M1;
    assign start_beats = LEN_WIDTH'(bytes_rnd >> BPB_LOG2);
    assign start_addr  = strDstAddr & ~ADDR_MASK;
    assign pri_w       = 4'(pri_q);

    // Map the latched one-hot priority to a beat limit; anything not one-hot uses priority 0.
    always_comb begin
        pri_beats = 9'(PRI_0_NUM_OF_BEATS + 1);
        case (pri_w)
            4'b0010: pri_beats = 9'(PRI_1_NUM_OF_BEATS + 1);
            4'b0100: pri_beats = 9'(PRI_2_NUM_OF_BEATS + 1);
            4'b1000: pri_beats = 9'(PRI_3_NUM_OF_BEATS + 1);
            default: pri_beats = 9'(PRI_0_NUM_OF_BEATS + 1);
        endcase
    end

    caxi4dma_burst_sizer #(
        .REM_WIDTH (LEN_WIDTH),
        .BPB_LOG2  (BPB_LOG2),
        .SPLIT_4K  (SPLIT_4K)
    ) u_sizer (
        .rem_beats_i   (rem_q),
        .pri_beats_i   (pri_beats),
        .addr_lo_i     (wrAddr_q[11:0]),
        .incr_i        (wrBurst_q == BURST_INCR),
        .burst_beats_o (sized_beats)
    );

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        pri_d      = pri_q;
        wrReq_d    = wrReq_q;
        wrAddr_d   = wrAddr_q;
        wrLen_d    = wrLen_q;
        wrBurst_d  = wrBurst_q;
        errAddr_d  = errAddr_q;
        tranDone_d = 1'b0;
        tranErr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (strTran) begin
                    wrAddr_d  = start_addr;
                    wrBurst_d = (strDstOp == DSTOP_INCR) ? BURST_INCR : BURST_FIXED;
                    pri_d     = strPri;
                    rem_d     = start_beats;
                    errAddr_d = '0;
                    if (strDstOp == DSTOP_ILLEGAL) begin
                        state_d   = ST_ERROR;
                        tranErr_d = 1'b1;
                        errAddr_d = start_addr;
                    end else if ((strDstOp == DSTOP_NOP) || (strBytes == '0)) begin
                        state_d    = ST_DONE;
                        tranDone_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                beats_d = sized_beats;
                wrLen_d = 8'(sized_beats - 9'd1);
                state_d = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (bufBeats >= beats_q) begin
                    wrReq_d = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wrReqAck) begin
                    wrReq_d = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (wrErr) begin
                    state_d   = ST_ERROR;
                    tranErr_d = 1'b1;
                    errAddr_d = wrAddr_q;
                end else if (wrDone) begin
                    rem_d = rem_q - LEN_WIDTH'(beats_q);
                    if (wrBurst_q == BURST_INCR) begin
                        wrAddr_d = wrAddr_q + (32'(beats_q) << BPB_LOG2);
                    end
                    if (rem_d == '0) begin
                        state_d    = ST_DONE;
                        tranDone_d = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: reset is sampled on the clock edge only; resetn is not in the sensitivity list.
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            beats_q    <= '0;
            pri_q      <= '0;
            wrReq_q    <= 1'b0;
            wrAddr_q   <= '0;
            wrLen_q    <= '0;
            wrBurst_q  <= '0;
            busy_q     <= 1'b0;
            tranDone_q <= 1'b0;
            tranErr_q  <= 1'b0;
            errAddr_q  <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            pri_q      <= pri_d;
            wrReq_q    <= wrReq_d;
            wrAddr_q   <= wrAddr_d;
            wrLen_q    <= wrLen_d;
            wrBurst_q  <= wrBurst_d;
            busy_q     <= busy_d;
            tranDone_q <= tranDone_d;
            tranErr_q  <= tranErr_d;
            errAddr_q  <= errAddr_d;
        end
    end

    assign wrReq    = wrReq_q;
    assign wrAddr   = wrAddr_q;
    assign wrLen    = wrLen_q;
    assign wrBurst  = wrBurst_q;
    assign busy     = busy_q;
    assign tranDone = tranDone_q;
    assign tranErr  = tranErr_q;
    assign errAddr  = errAddr_q;

endmodule

// File: tb/tb_caxi4dma_wr_tran_ctrl.sv
// Self-checking bench for caxi4dma_wr_tran_ctrl at DWIDTH=32 (4 bytes per beat)
// with four priority levels. Expected bursts come from a transfer-level model
// that slices the byte count into bursts with plain arithmetic.
module tb_caxi4dma_wr_tran_ctrl;

    localparam int LW = 23;

    logic        clock = 1'b0;
    logic        resetn;
    logic        strTran;
    logic [31:0] strDstAddr;
    logic [LW-1:0] strBytes;
    logic [1:0]  strDstOp;
    logic [3:0]  strPri;
    logic [8:0]  bufBeats;
    logic        wrReqAck, wrDone, wrErr;
    logic        wrReq;
    logic [31:0] wrAddr;
    logic [7:0]  wrLen;
    logic [1:0]  wrBurst;
    logic        busy, tranDone, tranErr;
    logic [31:0] errAddr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
    } burst_t;

    typedef struct {
        logic [31:0] addr;
        int          bytes;
        logic [1:0]  op;
        logic [3:0]  pri;
        int          err_idx;
        int          exp_n;
        bit          exp_done;
        bit          exp_err;
        logic [31:0] exp_eaddr;
    } vec_t;

    burst_t exp_q[$];
    vec_t   vecs[11];

    caxi4dma_wr_tran_ctrl #(
        .LEN_WIDTH    (LW),
        .DWIDTH       (32),
        .NUM_PRI_LVLS (4)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .strTran    (strTran),
        .strDstAddr (strDstAddr),
        .strBytes   (strBytes),
        .strDstOp   (strDstOp),
        .strPri     (strPri),
        .bufBeats   (bufBeats),
        .wrReqAck   (wrReqAck),
        .wrDone     (wrDone),
        .wrErr      (wrErr),
        .wrReq      (wrReq),
        .wrAddr     (wrAddr),
        .wrLen      (wrLen),
        .wrBurst    (wrBurst),
        .busy       (busy),
        .tranDone   (tranDone),
        .tranErr    (tranErr),
        .errAddr    (errAddr)
    );

    always #5 clock = ~clock;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transfer-level model: the list of bursts the controller must issue.
    task automatic build_model(input logic [31:0] addr, input int bytes,
                               input logic [1:0] op, input logic [3:0] pri);
        int rem, lim, n;
        logic [31:0] a;
        exp_q.delete();
        if (op == 2'b11 || op == 2'b00 || bytes == 0) return;
        rem = (bytes + 3) / 4;
        a = addr & 32'hFFFF_FFFC;
        case (pri)
            4'b0010: lim = 128;
            4'b0100: lim = 64;
            4'b1000: lim = 32;
            default: lim = 256;
        endcase
        while (rem > 0) begin
            n = (rem < lim) ? rem : lim;
`ifdef CAXI4DMA_WR_4K_SPLIT_EN
            if (op == 2'b01 && n > (4096 - int'(a[11:0])) / 4) n = (4096 - int'(a[11:0])) / 4;
`endif
            exp_q.push_back('{a, 8'(n - 1), (op == 2'b01) ? 2'b01 : 2'b00});
            if (op == 2'b01) a = a + 32'(n * 4);
            rem -= n;
        end
    endtask

    task automatic start(input logic [31:0] addr, input int bytes,
                         input logic [1:0] op, input logic [3:0] pri);
        strDstAddr = addr;
        strBytes   = LW'(bytes);
        strDstOp   = op;
        strPri     = pri;
        strTran    = 1'b1;
        tick();
        strTran    = 1'b0;
    endtask

    // Acts as the write master: accepts bursts, answers with B responses.
    task automatic serve(input int err_idx, input bit noise, output int nb,
                         output bit got_done, output bit got_err, output logic [31:0] eaddr);
        int budget, hold, dly;
        bit timed_out;
        nb = 0; got_done = 0; got_err = 0; eaddr = '0; budget = 0; timed_out = 1;
        while (budget < 5000) begin
            if (tranDone || tranErr) begin
                got_done = tranDone;
                got_err  = tranErr;
                eaddr    = errAddr;
                timed_out = 0;
                tick();
                check("pulse_one_cycle", {tranDone, tranErr}, 2'b00);
                check("busy_back_idle", busy, 0);
                break;
            end
            if (wrReq) begin
                check("busy_during_req", busy, 1);
                if (nb < exp_q.size()) begin
                    check("burst_addr", wrAddr, exp_q[nb].addr);
                    check("burst_len", wrLen, exp_q[nb].len);
                    check("burst_type", wrBurst, exp_q[nb].burst);
                end else begin
                    check("extra_wrReq", nb, exp_q.size());
                end
                hold = $urandom_range(0, 2);
                repeat (hold) begin
                    tick();
                    check("req_hold", wrReq, 1);
                    if (nb < exp_q.size()) begin
                        check("req_hold_addr", wrAddr, exp_q[nb].addr);
                        check("req_hold_len", wrLen, exp_q[nb].len);
                    end
                end
                wrReqAck = 1'b1;
                tick();
                wrReqAck = 1'b0;
                check("req_drop_after_ack", wrReq, 0);
                dly = $urandom_range(0, 3);
                repeat (dly) begin
                    if (noise) begin
                        strTran  = 1'b1;
                        strDstOp = 2'b11;
                    end
                    tick();
                    strTran = 1'b0;
                end
                wrDone = 1'b1;
                wrErr  = (nb == err_idx);
                tick();
                wrDone = 1'b0;
                wrErr  = 1'b0;
                nb++;
                if (nb - 1 == err_idx)       check("err_pulse_timing", tranErr, 1);
                else if (nb == exp_q.size()) check("done_pulse_timing", tranDone, 1);
                budget++;
            end else begin
                tick();
                budget++;
            end
        end
        check("serve_timeout", timed_out, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nb;
        bit d, e;
        logic [31:0] ea;
        build_model(v.addr, v.bytes, v.op, v.pri);
        start(v.addr, v.bytes, v.op, v.pri);
        serve(v.err_idx, 1'b1, nb, d, e, ea);
        check({tag, "_nbursts"}, nb, v.exp_n);
        check({tag, "_done"}, d, v.exp_done);
        check({tag, "_err"}, e, v.exp_err);
        if (v.exp_err) begin
            check({tag, "_err_addr"}, ea, v.exp_eaddr);
            check({tag, "_err_addr_hold"}, errAddr, v.exp_eaddr);
        end
    endtask

    task automatic zero_checks(input string tag);
        check({tag, "_wrReq"}, wrReq, 0);
        check({tag, "_wrAddr"}, wrAddr, 0);
        check({tag, "_wrLen"}, wrLen, 0);
        check({tag, "_wrBurst"}, wrBurst, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tranDone"}, tranDone, 0);
        check({tag, "_tranErr"}, tranErr, 0);
        check({tag, "_errAddr"}, errAddr, 0);
    endtask

    task automatic wait_req();
        int k = 0;
        while (!wrReq && k < 50) begin
            tick();
            k++;
        end
        check("wait_req", wrReq, 1);
    endtask

    initial begin
        int lat, nb;
        bit d, e;
        logic [31:0] ea;
        vec_t rv;

        vecs[0]  = '{32'h0000_1000,   64, 2'b01, 4'b0001, -1, 1, 1, 0, 32'h0};
        vecs[1]  = '{32'h0000_0000, 2048, 2'b01, 4'b0010, -1, 4, 1, 0, 32'h0};
`ifdef CAXI4DMA_WR_4K_SPLIT_EN
        vecs[2]  = '{32'h0000_0FF0,   64, 2'b01, 4'b0001, -1, 2, 1, 0, 32'h0};
        vecs[10] = '{32'hFFFF_FF00,  512, 2'b01, 4'b0001, -1, 2, 1, 0, 32'h0};
`else
        vecs[2]  = '{32'h0000_0FF0,   64, 2'b01, 4'b0001, -1, 1, 1, 0, 32'h0};
        vecs[10] = '{32'hFFFF_FF00,  512, 2'b01, 4'b0001, -1, 1, 1, 0, 32'h0};
`endif
        vecs[3]  = '{32'h0000_0000, 2048, 2'b01, 4'b0010,  1, 2, 0, 1, 32'h200};
        vecs[4]  = '{32'h0000_0100,    0, 2'b01, 4'b0001, -1, 0, 1, 0, 32'h0};
        vecs[5]  = '{32'h0000_0100,   16, 2'b11, 4'b0001, -1, 0, 0, 1, 32'h100};
        vecs[6]  = '{32'h0000_2000,   40, 2'b00, 4'b0001, -1, 0, 1, 0, 32'h0};
        vecs[7]  = '{32'h0000_3000,  600, 2'b10, 4'b1000, -1, 5, 1, 0, 32'h0};
        vecs[8]  = '{32'h0000_1003,    5, 2'b01, 4'b0100, -1, 1, 1, 0, 32'h0};
        vecs[9]  = '{32'h0000_4000, 1200, 2'b01, 4'b0011, -1, 2, 1, 0, 32'h0};

        resetn = 1'b0; strTran = 0; strDstAddr = '0; strBytes = '0; strDstOp = '0;
        strPri = '0; bufBeats = 9'd256; wrReqAck = 0; wrDone = 0; wrErr = 0;
        repeat (3) tick();
        zero_checks("reset");
        resetn = 1'b1;
        tick();

        // Minimum command-to-request latency.
        build_model(32'h0000_1000, 64, 2'b01, 4'b0001);
        start(32'h0000_1000, 64, 2'b01, 4'b0001);
        lat = 1;
        while (!wrReq && lat < 20) begin
            tick();
            lat++;
        end
        check("str_to_req_latency", lat, 3);
        serve(-1, 1'b0, nb, d, e, ea);
        check("lat_nbursts", nb, 1);
        check("lat_done", d, 1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Data-buffer stall: 16-beat burst waits until 16 beats are buffered.
        bufBeats = 9'd10;
        build_model(32'h0000_5000, 64, 2'b01, 4'b0001);
        start(32'h0000_5000, 64, 2'b01, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stall_no_req", wrReq, 0);
        end
        bufBeats = 9'd15;
        tick();
        check("stall_15_no_req", wrReq, 0);
        bufBeats = 9'd16;
        tick();
        check("stall_req_rise", wrReq, 1);
        bufBeats = 9'd256;
        serve(-1, 1'b0, nb, d, e, ea);
        check("stall_done", d, 1);

        // Reset while waiting for the B response.
        start(32'h0000_0000, 2048, 2'b01, 4'b0010);
        wait_req();
        wrReqAck = 1'b1;
        tick();
        wrReqAck = 1'b0;
        resetn = 1'b0;
        tick();
        zero_checks("rst_in_resp");
        resetn = 1'b1;
        // Late responses while idle must be ignored.
        wrDone = 1'b1; wrErr = 1'b1;
        tick();
        wrDone = 1'b0; wrErr = 1'b0;
        check("idle_resp_ignored_err", tranErr, 0);
        check("idle_resp_ignored_busy", busy, 0);

        // Reset while wrReq is high.
        start(32'h0000_0000, 2048, 2'b01, 4'b0010);
        wait_req();
        resetn = 1'b0;
        tick();
        zero_checks("rst_in_req");
        resetn = 1'b1;
        tick();
        run_vec(vecs[0], "post_reset");

        // Randomized transfers against the model.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rv.op    = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
            rv.addr  = $urandom;
            rv.bytes = $urandom_range(0, 3000);
            case ($urandom_range(0, 5))
                0: rv.pri = 4'b0001;
                1: rv.pri = 4'b0010;
                2: rv.pri = 4'b0100;
                3: rv.pri = 4'b1000;
                4: rv.pri = 4'b0000;
                default: rv.pri = 4'b0110;
            endcase
            build_model(rv.addr, rv.bytes, rv.op, rv.pri);
            rv.err_idx = -1;
            if (exp_q.size() > 0 && $urandom_range(0, 3) == 0)
                rv.err_idx = $urandom_range(0, exp_q.size() - 1);
            if (rv.op == 2'b11) begin
                rv.exp_n = 0; rv.exp_done = 0; rv.exp_err = 1;
                rv.exp_eaddr = rv.addr & 32'hFFFF_FFFC;
            end else if (rv.err_idx >= 0) begin
                rv.exp_n = rv.err_idx + 1; rv.exp_done = 0; rv.exp_err = 1;
                rv.exp_eaddr = exp_q[rv.err_idx].addr;
            end else begin
                rv.exp_n = exp_q.size(); rv.exp_done = 1; rv.exp_err = 0;
                rv.exp_eaddr = '0;
            end
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
